multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the 64-bit multicycle processor. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select: PC, instruction register, memory address/write, ALU sources, result mux and the register-file `Regwrite`. It also decodes ALU operation and immediate format, and stalls on a memory-ready handshake.

## Interface
Parameters: none (opcode and state encodings are fixed below).

- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 7: instr[6:0] from instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes current access this cycle.
- `PCWrite` out 1: PC load enable = PCUpdate | (Branch & zero).
- `AdrSrc` out 1: 0 = PC, 1 = ALU result register.
- `MemWrite` out 1: data memory write.
- `IRWrite` out 1: instruction register load (also latches OldPC).
- `Regwrite` out 1: register-file write enable.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1 register.
- `ALUSrcB` out 2: 00 RD2 register, 01 ImmExt, 10 constant 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J.
- `illegal` out 1: one-cycle pulse on unrecognized opcode.
- `state` out 4: current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11–15 → FETCH next cycle, with all enables 0.
- Transitions:
  - FETCH → DECODE when `mem_ready`; otherwise hold.
  - DECODE dispatches on opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - anything else → FETCH with `illegal` = 1.
  - MEMADR → MEMREAD if opcode[5] = 0, else MEMWRITE.
  - MEMREAD → MEMWB when `mem_ready`; otherwise hold.
  - MEMWRITE → FETCH when `mem_ready`; otherwise hold.
  - MEMWB → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
  - ALUWB → FETCH.
  - JAL → ALUWB.
  - BEQ → FETCH.
- Outputs per state. Every signal not listed is 0.
  - FETCH: IRWrite = PCUpdate = `mem_ready`; ALUSrcB 10; ResultSrc 10; ALUOp 00.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1.
  - MEMWRITE: AdrSrc 1, MemWrite 1 (held until `mem_ready`).
  - MEMWB: ResultSrc 01, Regwrite 1.
  - EXECUTER: ALUSrcA 10, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: Regwrite 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, PCUpdate 1.
  - BEQ: ALUSrcA 10, ALUOp 01, Branch 1.
- ALU decode (combinational):
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by funct3:
    - 000 → sub if (opcode[5] & funct7b5), else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - other → add.
- ImmSrc (combinational from opcode):
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - all else → 00.
- Write to x0 is suppressed by the register file, not here.

## Timing
- Reset: `rst_n` low immediately forces state = FETCH, regardless of clock.
  - While `rst_n` = 0, PCWrite, IRWrite, MemWrite, Regwrite and `illegal` are forced 0.
  - All other outputs take FETCH values.
- Reset deasserting mid-instruction: the instruction is abandoned; no partial writeback occurs.
- Latency, cycles from FETCH entry with `mem_ready` held 1:
  - load 5, store 4, R-type 4, I-ALU 4, jal 4, beq 3.
  - Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- PCWrite in BEQ depends combinationally on `zero` in that same cycle.
- Regwrite is asserted for exactly one cycle per load, R-type, I-ALU or jal; never for sw, beq or illegal.
- MemWrite stays high continuously in MEMWRITE until the cycle `mem_ready` = 1, inclusive; that cycle is the write.
- `illegal` is high only in the DECODE cycle; no datapath enable is asserted for an illegal instruction.

## Test plan
- Reset: pull `rst_n` low mid-cycle while in MEMWB → `state` becomes 0 immediately and Regwrite drops to 0 before the next edge. Release with `mem_ready` = 1 → DECODE after one edge.
- Load: `opcode` 0000011, `mem_ready` = 1 → states 0,1,2,3,4,0. Regwrite only in state 4 with ResultSrc 01. Repeat with `mem_ready` low for 2 cycles in MEMREAD → latency 7.
- Store: `opcode` 0100011 with a 3-cycle stall in MEMWRITE → MemWrite high for 4 consecutive cycles, AdrSrc 1, ImmSrc 01, Regwrite never 1.
- R-type sub: `funct3` 000, `funct7b5` 1 → ALUControl 001 in EXECUTER. I-type addi with `funct7b5` 1 → ALUControl 000. `funct3` 010 → 101.
- beq: `opcode` 1100011 → PCWrite = 1 in BEQ only when `zero` = 1, ALUControl 001, 3 cycles total. jal → PCWrite in JAL, then Regwrite in ALUWB.
- Illegal: `opcode` 1111111 → `illegal` pulse in DECODE, next state FETCH, no enable asserted.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the 64-bit multicycle core.
// Moore state machine plus combinational ALU and immediate decoders.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       Regwrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic is_ld;
  logic is_st;
  logic is_r;
  logic is_i;
  logic is_jal;
  logic is_beq;
  logic legal;

  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_op;

  assign is_ld  = (opcode == 7'b0000011);
  assign is_st  = (opcode == 7'b0100011);
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_jal = (opcode == 7'b1101111);
  assign is_beq = (opcode == 7'b1100011);
  assign legal  = is_ld | is_st | is_r | is_i | is_jal | is_beq;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_ld, is_st: state_d = S_MEMADR;
          is_r:         state_d = S_EXECUTER;
          is_i:         state_d = S_EXECUTEI;
          is_jal:       state_d = S_JAL;
          is_beq:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write  = mem_ready;
        pc_update = mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are gated by rst_n so nothing fires while reset is held.
  assign PCWrite  = rst_n & (pc_update | (branch & zero));
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign Regwrite = rst_n & reg_write;
  assign illegal  = rst_n & (state_q == S_DECODE) & ~legal;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      is_st:   ImmSrc = 2'b01;
      is_beq:  ImmSrc = 2'b10;
      is_jal:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed reset steps, then random
// instruction streams checked cycle by cycle against a reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       Regwrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .Regwrite(Regwrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // instruction classes
  localparam int LD = 0, ST = 1, RT = 2, IT = 3, JL = 4, BQ = 5, IL = 6;

  function automatic int klass(input logic [6:0] op);
    case (op)
      7'b0000011: return LD;
      7'b0100011: return ST;
      7'b0110011: return RT;
      7'b0010011: return IT;
      7'b1101111: return JL;
      7'b1100011: return BQ;
      default:    return IL;
    endcase
  endfunction

  function automatic logic [2:0] func_alu(input logic [2:0] f3,
                                          input bit use_sub);
    case (f3)
      3'b000:  return use_sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // {PCWrite,AdrSrc,MemWrite,IRWrite,Regwrite,ResultSrc,ALUSrcA,
  //  ALUSrcB,ALUControl,ImmSrc,illegal}
  function automatic logic [16:0] model(input int s, input bit mr,
      input bit z, input logic [6:0] op, input logic [2:0] f3,
      input bit f7);
    bit pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm = 0;
    logic [2:0] alu = 0;
    int k = klass(op);
    imm = (k == ST) ? 2'b01 : (k == BQ) ? 2'b10 : (k == JL) ? 2'b11 : 2'b00;
    case (s)
      0: begin irw = mr; pcw = mr; sb = 2; rs = 2; end
      1: begin sa = 1; sb = 1; ill = (k == IL); end
      2: begin sa = 2; sb = 1; end
      3: adr = 1;
      4: begin rs = 1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin sa = 2; alu = func_alu(f3, op[5] & f7); end
      7: rw = 1;
      8: begin sa = 2; sb = 1; alu = func_alu(f3, op[5] & f7); end
      9: begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'b001; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, Regwrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input bit f7);
    int qs[$];
    bit qm[$];
    int k = klass(op);
    int s0 = $urandom_range(0, 2);
    int sm = $urandom_range(0, 3);
    int rw_cnt = 0;
    int mw_cnt = 0;
    repeat (s0) begin qs.push_back(0); qm.push_back(0); end
    qs.push_back(0); qm.push_back(1);
    qs.push_back(1); qm.push_back(1'($urandom));
    case (k)
      LD: begin
        qs.push_back(2); qm.push_back(1'($urandom));
        repeat (sm) begin qs.push_back(3); qm.push_back(0); end
        qs.push_back(3); qm.push_back(1);
        qs.push_back(4); qm.push_back(1'($urandom));
      end
      ST: begin
        qs.push_back(2); qm.push_back(1'($urandom));
        repeat (sm) begin qs.push_back(5); qm.push_back(0); end
        qs.push_back(5); qm.push_back(1);
      end
      RT: begin qs.push_back(6); qs.push_back(7); qm.push_back(1); qm.push_back(0); end
      IT: begin qs.push_back(8); qs.push_back(7); qm.push_back(0); qm.push_back(1); end
      JL: begin qs.push_back(9); qs.push_back(7); qm.push_back(1); qm.push_back(1); end
      BQ: begin qs.push_back(10); qm.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < qs.size(); i++) begin
      @(negedge clk);
      opcode    = op;
      funct3    = f3;
      funct7b5  = f7;
      mem_ready = qm[i];
      zero      = 1'($urandom);
      #1;
      check($sformatf("state op=%b step=%0d", op, i), 32'(state), 32'(qs[i]));
      check($sformatf("outs op=%b st=%0d mr=%0b z=%0b", op, qs[i], qm[i], zero),
            32'(observed()), 32'(model(qs[i], qm[i], zero, op, f3, f7)));
      rw_cnt += int'(Regwrite);
      mw_cnt += int'(MemWrite);
    end
    check($sformatf("regwrite_count op=%b", op), 32'(rw_cnt),
          32'((k == LD || k == RT || k == IT || k == JL) ? 1 : 0));
    check($sformatf("memwrite_count op=%b", op), 32'(mw_cnt),
          32'((k == ST) ? sm + 1 : 0));
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [2:0] f3s [5];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100011, 7'b1111111, 7'b0000000};
    f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001};

    // reset held: FETCH values with enables forced low
    rst_n = 0; mem_ready = 1; opcode = 7'b0000011;
    funct3 = 0; funct7b5 = 0; zero = 1;
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'(observed()), 32'(17'b0_0_0_0_0_10_00_10_000_00_0));

    // run a load into MEMWB, then reset mid-cycle
    @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    #1;
    check("ld_at_memwb", 32'(state), 32'd4);
    check("ld_regwrite", 32'(Regwrite), 32'd1);
    #2 rst_n = 0;
    #1;
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_regwrite", 32'(Regwrite), 32'd0);
    check("async_reset_irwrite", 32'(IRWrite), 32'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    check("release_to_decode", 32'(state), 32'd1);
    mem_ready = 0;
    #1 rst_n = 0;
    #1 rst_n = 1;

    for (int n = 0; n < 320; n++) begin
      logic [6:0] op;
      op = ops[n % 8];
      if (n % 8 == 7) op = 7'($urandom);
      run_instr(op, f3s[$urandom_range(0, 4)], 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
